mem_initiator: RTL

Bus-side initiator for the single-port synchronous memory (`device`) interface. Accepts burst commands over a valid/ready handshake and drives `address`/`write_en`/`read_en`/`data_wr` toward the memory. Captures `data_rd` and returns read words over a valid/ready response channel with backpressure. Sits between test/control logic and the memory instance, and is the counterpart that drives that memory's port.

---
 rtl/mem_initiator_pkg.sv | 16 +
 rtl/mem_initiator.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/mem_initiator_pkg.sv
// Shared types and default widths for the memory-port initiator.
package mem_initiator_pkg;

    localparam int unsigned MI_ADDRESS_W = 4;
    localparam int unsigned MI_DATA_W    = 8;
    localparam int unsigned MI_LEN_W     = 4;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD_ISS,
        RD_CAP,
        RD_RSP
    } mi_state_t;

endpackage

// File: rtl/mem_initiator.sv
// Burst initiator for a single-port synchronous memory.
// Ports:
//   clk, rst (async, active-low)
//   cmd_*    : burst command channel (valid/ready), fill-value writes or reads
//   rsp_*    : read-word response channel with backpressure
//   done     : one-cycle pulse at burst completion; busy: state is not IDLE
//   address/write_en/read_en/data_wr/data_rd : memory port
module mem_initiator
    import mem_initiator_pkg::*;
#(
    parameter int unsigned ADDRESS_W = MI_ADDRESS_W,
    parameter int unsigned DATA_W    = MI_DATA_W,
    parameter int unsigned LEN_W     = MI_LEN_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_write,
    input  logic [ADDRESS_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]     cmd_len,
    input  logic [DATA_W-1:0]    cmd_wdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [DATA_W-1:0]    rsp_data,
    output logic [ADDRESS_W-1:0] rsp_addr,
    output logic                 rsp_last,
    output logic                 done,
    output logic                 busy,
    output logic [ADDRESS_W-1:0] address,
    output logic                 write_en,
    output logic                 read_en,
    output logic [DATA_W-1:0]    data_wr,
    input  logic [DATA_W-1:0]    data_rd
);

    mi_state_t            state_q, state_d;
    logic [LEN_W-1:0]     beats_q, beats_d;
    logic [ADDRESS_W-1:0] address_d, rsp_addr_d;
    logic [DATA_W-1:0]    data_wr_d, rsp_data_d;
    logic                 write_en_d, read_en_d, done_d, busy_d;
    logic                 rsp_valid_d, rsp_last_d;

    // Only combinational output: the command slot is open exactly in IDLE.
    assign cmd_ready = (state_q == IDLE);

    // State and registered-output register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            beats_q   <= '0;
            address   <= '0;
            data_wr   <= '0;
            write_en  <= 1'b0;
            read_en   <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_addr  <= '0;
            rsp_last  <= 1'b0;
        end else begin
            state_q   <= state_d;
            beats_q   <= beats_d;
            address   <= address_d;
            data_wr   <= data_wr_d;
            write_en  <= write_en_d;
            read_en   <= read_en_d;
            done      <= done_d;
            busy      <= busy_d;
            rsp_valid <= rsp_valid_d;
            rsp_data  <= rsp_data_d;
            rsp_addr  <= rsp_addr_d;
            rsp_last  <= rsp_last_d;
        end
    end

    // Next state and next values of every registered output.
    // The address register doubles as the burst's current address; it wraps naturally.
    always_comb begin
        state_d     = state_q;
        beats_d     = beats_q;
        address_d   = address;
        data_wr_d   = data_wr;
        write_en_d  = 1'b0;
        read_en_d   = 1'b0;
        done_d      = 1'b0;
        rsp_valid_d = rsp_valid;
        rsp_data_d  = rsp_data;
        rsp_addr_d  = rsp_addr;
        rsp_last_d  = rsp_last;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    address_d = cmd_addr;
                    beats_d   = cmd_len;
                    if (cmd_write) begin
                        data_wr_d  = cmd_wdata;
                        write_en_d = 1'b1;
                        state_d    = WR;
                    end else begin
                        read_en_d = 1'b1;
                        state_d   = RD_ISS;
                    end
                end
            end
            WR: begin
                if (beats_q == '0) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    address_d  = address + ADDRESS_W'(1);
                    beats_d    = beats_q - LEN_W'(1);
                    write_en_d = 1'b1;
                end
            end
            RD_ISS: begin
                // Memory samples read_en at this edge; data arrives next cycle.
                state_d = RD_CAP;
            end
            RD_CAP: begin
                rsp_data_d  = data_rd;
                rsp_addr_d  = address;
                rsp_valid_d = 1'b1;
                rsp_last_d  = (beats_q == '0);
                state_d     = RD_RSP;
            end
            RD_RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if (rsp_last) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        address_d = address + ADDRESS_W'(1);
                        beats_d   = beats_q - LEN_W'(1);
                        read_en_d = 1'b1;
                        state_d   = RD_ISS;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

endmodule
